// File: rtl/mem_arbiter_if.sv
// Bundle of the two master request ports and the memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the side driving requests and memory status.
interface mem_arbiter_if;
    logic        M0_req;
    logic        M1_req;
    logic        M0_write;
    logic        M1_write;
    logic [1:0]  M0_size;
    logic [1:0]  M1_size;
    logic [15:0] M0_addr;
    logic [15:0] M1_addr;
    logic [15:0] M0_wdata;
    logic [15:0] M1_wdata;
    logic        M0_gnt;
    logic        M1_gnt;
    logic        M0_done;
    logic        M1_done;
    logic        M0_err;
    logic        M1_err;
    logic [15:0] M0_rdata;
    logic [15:0] M1_rdata;
    logic        MEM_exec;
    logic        MEM_write;
    logic [1:0]  MEM_size;
    logic [15:0] MEM_addr;
    logic [15:0] MEM_data_out;
    logic        MEM_ready;
    logic        MEM_data_ready;
    logic [15:0] MEM_data_in;

    modport slave (
        input  M0_req, M1_req, M0_write, M1_write, M0_size, M1_size,
        input  M0_addr, M1_addr, M0_wdata, M1_wdata,
        input  MEM_ready, MEM_data_ready, MEM_data_in,
        output M0_gnt, M1_gnt, M0_done, M1_done, M0_err, M1_err,
        output M0_rdata, M1_rdata,
        output MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out
    );

    modport master (
        output M0_req, M1_req, M0_write, M1_write, M0_size, M1_size,
        output M0_addr, M1_addr, M0_wdata, M1_wdata,
        output MEM_ready, MEM_data_ready, MEM_data_in,
        input  M0_gnt, M1_gnt, M0_done, M1_done, M0_err, M1_err,
        input  M0_rdata, M1_rdata,
        input  MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a single memory port with alternating priority under
// contention and a WAIT-state timeout that aborts the access with an error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          I_clk,
    input  logic          I_reset_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_owner;
    logic       r_last;
    logic [7:0] r_wait_cnt;
    logic       w_any;
    logic       w_pick;

    // Owner/last encoding: 0 = M0, 1 = M1.
    assign w_any  = bus.M0_req | bus.M1_req;
    assign w_pick = (bus.M0_req & bus.M1_req) ? ~r_last : bus.M1_req;

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state          <= IDLE;
            r_owner          <= 1'b0;
            r_last           <= 1'b1;
            r_wait_cnt       <= '0;
            bus.M0_gnt       <= 1'b0;
            bus.M1_gnt       <= 1'b0;
            bus.M0_done      <= 1'b0;
            bus.M1_done      <= 1'b0;
            bus.M0_err       <= 1'b0;
            bus.M1_err       <= 1'b0;
            bus.M0_rdata     <= '0;
            bus.M1_rdata     <= '0;
            bus.MEM_exec     <= 1'b0;
            bus.MEM_write    <= 1'b0;
            bus.MEM_size     <= '0;
            bus.MEM_addr     <= '0;
            bus.MEM_data_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.MEM_ready && w_any) begin
                        r_owner          <= w_pick;
                        r_last           <= w_pick;
                        bus.MEM_write    <= w_pick ? bus.M1_write : bus.M0_write;
                        bus.MEM_size     <= w_pick ? bus.M1_size  : bus.M0_size;
                        bus.MEM_addr     <= w_pick ? bus.M1_addr  : bus.M0_addr;
                        bus.MEM_data_out <= w_pick ? bus.M1_wdata : bus.M0_wdata;
                        bus.M0_gnt       <= ~w_pick;
                        bus.M1_gnt       <= w_pick;
                        bus.MEM_exec     <= 1'b1;
                        r_state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.M0_gnt   <= 1'b0;
                    bus.M1_gnt   <= 1'b0;
                    bus.MEM_exec <= 1'b0;
                    r_wait_cnt   <= '0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    // Data arriving on the timeout cycle still completes normally.
                    if (bus.MEM_data_ready) begin
                        if (!bus.MEM_write) begin
                            if (r_owner) bus.M1_rdata <= bus.MEM_data_in;
                            else         bus.M0_rdata <= bus.MEM_data_in;
                        end
                        bus.M0_done <= ~r_owner;
                        bus.M1_done <= r_owner;
                        bus.M0_err  <= 1'b0;
                        bus.M1_err  <= 1'b0;
                        r_state     <= DONE;
                    end else if (r_wait_cnt == LP_LAST_WAIT) begin
                        if (!bus.MEM_write) begin
                            if (r_owner) bus.M1_rdata <= 16'hFFFF;
                            else         bus.M0_rdata <= 16'hFFFF;
                        end
                        bus.M0_done <= ~r_owner;
                        bus.M1_done <= r_owner;
                        bus.M0_err  <= ~r_owner;
                        bus.M1_err  <= r_owner;
                        r_state     <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    bus.M0_done      <= 1'b0;
                    bus.M1_done      <= 1'b0;
                    bus.M0_err       <= 1'b0;
                    bus.M1_err       <= 1'b0;
                    bus.MEM_write    <= 1'b0;
                    bus.MEM_size     <= '0;
                    bus.MEM_addr     <= '0;
                    bus.MEM_data_out <= '0;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, which sets the maximum number of WAIT cycles before an access aborts (legal range 2..255).
REQ-003 I_clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 I_reset_n  in  1  asynchronous active-low reset.
REQ-005 M0_req, M1_req  in  1 each  level access request; the master SHALL hold it until it receives Mx_gnt.
REQ-006 Mx_write  in  1  1 = write, 0 = read.
REQ-007 Mx_size  in  2  access size, forwarded unchanged.
REQ-008 Mx_addr, Mx_wdata  in  16 each  address and write data.
REQ-009 Mx_gnt  out  1  one-cycle pulse: request accepted, fields latched.
REQ-010 Mx_done  out  1  one-cycle pulse: access complete.
REQ-011 Mx_err  out  1  valid with Mx_done; 1 = timeout abort.
REQ-012 Mx_rdata  out  16  read data; it SHALL be held until that master's next Mx_done.
REQ-013 MEM_exec, MEM_write  out  1 each; MEM_size  out  2; MEM_addr, MEM_data_out  out  16 each; memory port.
REQ-014 MEM_ready, MEM_data_ready  in  1 each; MEM_data_in  in  16; memory status and read data.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and DONE. All outputs SHALL be registered.
REQ-016 IDLE: the block SHALL sample a request only when it is in IDLE and MEM_ready=1. When any req is high, it SHALL select a winner, latch that master's write/size/addr/wdata, set Mx_gnt=1 and MEM_exec=1 for the next cycle, and go to ISSUE.
REQ-017 Arbitration: if only one req is high, that master SHALL win. If both are high, the master not granted last SHALL win. last_grant SHALL reset to M1, so M0 wins the first contention.
REQ-018 ISSUE lasts exactly one cycle: MEM_exec=1 and Mx_gnt=1 in the same cycle. The block SHALL then go to WAIT.
REQ-019 MEM_write, MEM_size, MEM_addr and MEM_data_out SHALL carry the latched fields throughout ISSUE, WAIT and DONE. In IDLE they SHALL be 0.
REQ-020 WAIT: on MEM_data_ready=1, the block SHALL capture MEM_data_in into the owner's Mx_rdata (reads only; writes leave Mx_rdata unchanged), set err=0, and go to DONE.
REQ-021 WAIT: a 8-bit wait_cnt SHALL clear on entry and increment each WAIT cycle without MEM_data_ready.
REQ-022 When wait_cnt = TIMEOUT-1 and MEM_data_ready=0, the block SHALL go to DONE with err=1. For a read, Mx_rdata SHALL become 16'hFFFF.
REQ-023 Simultaneous MEM_data_ready and timeout: MEM_data_ready SHALL take priority, giving a normal completion with err=0.
REQ-024 DONE lasts exactly one cycle, with the owner's Mx_done=1 and Mx_err valid. The block SHALL then return to IDLE. Latency from MEM_data_ready to Mx_done is 1 cycle.
REQ-025 MEM_data_ready outside WAIT SHALL be ignored. Requests during ISSUE, WAIT or DONE SHALL be ignored until IDLE.
REQ-026 Minimum occupancy is 4 cycles per access (IDLE sample, ISSUE, WAIT ≥1, DONE). Back-to-back grants SHALL be possible with no extra idle cycle beyond IDLE.
REQ-027 The non-owner's gnt, done and err SHALL stay 0 throughout.

Reset
REQ-028 Asserting I_reset_n=0 at any time, including mid-access, SHALL immediately force the following:
- state=IDLE;
- all Mx_gnt, Mx_done, Mx_err, MEM_exec and MEM_write = 0;
- MEM_size, MEM_addr, MEM_data_out, M0_rdata and M1_rdata = 0;
- wait_cnt=0;
- last_grant=M1.
REQ-029 After release, the first sampling SHALL occur on the first rising edge with I_reset_n=1. An in-flight access is not resumed.

Verification
REQ-030 Single read: M0 reads addr 16'h0100, memory returns 16'hBEEF 3 cycles after MEM_exec. Required: M0_gnt and MEM_exec both in cycle 1; M0_done in the cycle after MEM_data_ready; M0_rdata=16'hBEEF; M0_err=0.
REQ-031 Contention: M0 and M1 both request continuously from reset. Required: grants alternate M0, M1, M0, M1; each done matches the preceding gnt.
REQ-032 Write: M1 writes 16'h1234 to 16'h0200, size 1. Required: MEM_write=1, MEM_addr=16'h0200, MEM_data_out=16'h1234, MEM_size=1 held until DONE; M1_rdata unchanged.
REQ-033 Timeout: with TIMEOUT=8, the memory never asserts MEM_data_ready. Required: done in cycle ISSUE+9 with err=1 and rdata=16'hFFFF; a later access succeeds normally.
REQ-034 Collision: MEM_data_ready arrives exactly on the timeout cycle. Required: err=0 and data captured.
REQ-035 Reset mid-WAIT. Required: all outputs 0 immediately; no done pulse; a new request is then granted to M0 first.
